// File: rtl/ps2_key_event_rx_pkg.sv
// ============================================================================
// ps2_key_event_rx_pkg : scan-code set 2 constants, event record, helpers
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_key_event_rx_pkg;

   localparam logic [7:0] c_code_e0     = 8'hE0;
   localparam logic [7:0] c_code_f0     = 8'hF0;
   localparam logic [7:0] c_code_e1     = 8'hE1;
   localparam logic [7:0] c_code_aa     = 8'hAA;
   localparam logic [7:0] c_code_fa     = 8'hFA;
   localparam logic [7:0] c_code_fe     = 8'hFE;
   localparam logic [7:0] c_code_ee     = 8'hEE;
   localparam logic [7:0] c_code_00     = 8'h00;
   localparam logic [7:0] c_code_ff     = 8'hFF;

   localparam logic [7:0] c_code_lshift = 8'h12;
   localparam logic [7:0] c_code_rshift = 8'h59;
   localparam logic [7:0] c_code_ctrl   = 8'h14;
   localparam logic [7:0] c_code_alt    = 8'h11;

   localparam int c_mod_lshift = 0;
   localparam int c_mod_rshift = 1;
   localparam int c_mod_ctrl   = 2;
   localparam int c_mod_alt    = 3;

   // Bytes swallowed after an E1 prefix (remainder of the Pause sequence)
   localparam logic [2:0] c_pause_skip = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic [3:0] mods;
   } key_event_t;

   // Keyboard replies and fill bytes that never form a key event
   function automatic logic is_reply_code(input logic [7:0] code);
      return (code == c_code_aa) || (code == c_code_fa) || (code == c_code_fe) ||
             (code == c_code_ee) || (code == c_code_00) || (code == c_code_ff);
   endfunction

   // Shift keys only count without E0; ctrl/alt count either way
   function automatic logic [3:0] apply_mods(input logic [3:0] cur, input logic [7:0] code,
                                             input logic ext, input logic brk);
      logic [3:0] m;
      m = cur;
      if (code == c_code_ctrl)
         m[c_mod_ctrl] = !brk;
      else if (code == c_code_alt)
         m[c_mod_alt] = !brk;
      else if (!ext && (code == c_code_lshift))
         m[c_mod_lshift] = !brk;
      else if (!ext && (code == c_code_rshift))
         m[c_mod_rshift] = !brk;
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// ============================================================================
// ps2_frame_rx : pin synchroniser, ps2_clk edge filter, 11-bit frame deframer
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_frame_rx
   import ps2_key_event_rx_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       err_parity,
   output logic       err_frame
);

   localparam int c_half   = FILTER_LEN / 2;
   localparam int c_tmr_w  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FILTER_LEN-1:0] c_edge_pattern = {{c_half{1'b1}}, {c_half{1'b0}}};
   localparam logic [c_tmr_w-1:0]    c_timeout_last = c_tmr_w'(TIMEOUT_CYCLES - 1);

   logic                  r_clk_meta, r_clk_sync, r_data_meta, r_data_sync;
   logic [FILTER_LEN-1:0] r_hist;
   logic                  w_edge;

   frame_state_t          r_state, w_state_next;
   logic [7:0]            r_shift;
   logic [2:0]            r_bit_cnt;
   logic                  r_parity;
   logic [c_tmr_w-1:0]    r_timer;
   logic                  w_timeout, w_parity_ok;
   logic                  w_byte_valid, w_err_parity, w_err_frame;

   // Idle PS/2 lines are high, so the pipeline resets to ones to avoid a false edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_meta  <= 1'b1;
         r_clk_sync  <= 1'b1;
         r_data_meta <= 1'b1;
         r_data_sync <= 1'b1;
         r_hist      <= '1;
      end else begin
         r_clk_meta  <= ps2_clk;
         r_clk_sync  <= r_clk_meta;
         r_data_meta <= ps2_data;
         r_data_sync <= r_data_meta;
         r_hist      <= {r_hist[FILTER_LEN-2:0], r_clk_sync};
      end
   end

   assign w_edge      = (r_hist == c_edge_pattern);
   assign w_timeout   = (r_state != ST_IDLE) && (r_timer == c_timeout_last);
   assign w_parity_ok = ^{r_shift, r_parity};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   // An edge arriving in the last timeout cycle still counts as activity
   always_comb begin
      w_state_next = r_state;
      w_byte_valid = 1'b0;
      w_err_parity = 1'b0;
      w_err_frame  = 1'b0;
      if (w_edge) begin
         case (r_state)
            ST_IDLE:   if (!r_data_sync) w_state_next = ST_DATA;
            ST_DATA:   if (r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
            ST_PARITY: w_state_next = ST_STOP;
            ST_STOP: begin
               w_state_next = ST_IDLE;
               if (!w_parity_ok)
                  w_err_parity = 1'b1;
               else if (!r_data_sync)
                  w_err_frame = 1'b1;
               else
                  w_byte_valid = 1'b1;
            end
            default:   w_state_next = ST_IDLE;
         endcase
      end else if (w_timeout) begin
         w_state_next = ST_IDLE;
         w_err_frame  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_parity   <= 1'b0;
         r_timer    <= '0;
         byte_valid <= 1'b0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         byte_valid <= w_byte_valid;
         err_parity <= w_err_parity;
         err_frame  <= w_err_frame;
         if ((r_state == ST_IDLE) || w_edge)
            r_timer <= '0;
         else
            r_timer <= r_timer + 1'b1;
         if (w_edge) begin
            if (r_state == ST_IDLE)
               r_bit_cnt <= '0;
            if (r_state == ST_DATA) begin
               r_shift   <= {r_data_sync, r_shift[7:1]};
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state == ST_PARITY)
               r_parity <= r_data_sync;
         end
      end
   end

   assign byte_data = r_shift;

endmodule

`default_nettype wire

// File: rtl/ps2_key_event_rx.sv
// ============================================================================
// ps2_key_event_rx : PS/2 set-2 receiver, prefix decoder, modifiers, event FIFO
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_event_rx
   import ps2_key_event_rx_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [7:0]                    ev_code,
   output logic                          ev_ext,
   output logic                          ev_break,
   output logic [3:0]                    ev_mods,
   output logic [3:0]                    mods,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          err_parity,
   output logic                          err_frame,
   output logic                          err_overflow
);

   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam logic [c_ptr_w:0] c_full_count = (c_ptr_w + 1)'(FIFO_DEPTH);

   logic             w_byte_valid;
   logic [7:0]       w_byte_data;

   logic             r_ext, r_brk, w_ext_next, w_brk_next;
   logic [2:0]       r_skip, w_skip_next;
   logic [3:0]       r_mods, w_mods_next;
   logic             w_emit;
   key_event_t       w_push_ev, w_head;

   key_event_t       r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
   logic [c_ptr_w:0] r_count;
   logic             w_full, w_pop, w_push_ok, r_err_overflow;

   ps2_frame_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (w_byte_valid),
      .byte_data  (w_byte_data),
      .err_parity (err_parity),
      .err_frame  (err_frame)
   );

   // Prefix decoder; a line error abandons any partially decoded sequence
   always_comb begin
      w_emit      = 1'b0;
      w_ext_next  = r_ext;
      w_brk_next  = r_brk;
      w_skip_next = r_skip;
      w_mods_next = r_mods;
      if (err_parity || err_frame) begin
         w_ext_next  = 1'b0;
         w_brk_next  = 1'b0;
         w_skip_next = '0;
      end else if (w_byte_valid) begin
         if (r_skip != 3'd0) begin
            w_skip_next = r_skip - 1'b1;
         end else if (w_byte_data == c_code_e0) begin
            w_ext_next = 1'b1;
         end else if (w_byte_data == c_code_f0) begin
            w_brk_next = 1'b1;
         end else if (w_byte_data == c_code_e1) begin
            w_skip_next = c_pause_skip;
            w_ext_next  = 1'b0;
            w_brk_next  = 1'b0;
         end else if (is_reply_code(w_byte_data)) begin
            w_ext_next = 1'b0;
            w_brk_next = 1'b0;
         end else begin
            w_emit      = 1'b1;
            w_ext_next  = 1'b0;
            w_brk_next  = 1'b0;
            w_mods_next = apply_mods(r_mods, w_byte_data, r_ext, r_brk);
         end
      end
   end

   assign w_push_ev = '{code: w_byte_data, ext: r_ext, brk: r_brk, mods: w_mods_next};

   assign ev_valid  = (r_count != '0);
   assign w_full    = (r_count == c_full_count);
   assign w_pop     = ev_valid && ev_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign w_push_ok = w_emit && (!w_full || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ext          <= 1'b0;
         r_brk          <= 1'b0;
         r_skip         <= '0;
         r_mods         <= '0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_err_overflow <= 1'b0;
      end else begin
         r_ext          <= w_ext_next;
         r_brk          <= w_brk_next;
         r_skip         <= w_skip_next;
         r_mods         <= w_mods_next;
         r_err_overflow <= w_emit && !w_push_ok;
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= w_push_ev;
   end

   // Storage is not reset, so the head is masked while the FIFO is empty
   assign w_head       = r_mem[r_rd_ptr];
   assign ev_code      = ev_valid ? w_head.code : 8'h00;
   assign ev_ext       = ev_valid ? w_head.ext  : 1'b0;
   assign ev_break     = ev_valid ? w_head.brk  : 1'b0;
   assign ev_mods      = ev_valid ? w_head.mods : 4'h0;
   assign mods         = r_mods;
   assign fifo_count   = r_count;
   assign err_overflow = r_err_overflow;

endmodule

`default_nettype wire
